// File: rtl/uart_verici.sv
// 8N1 UART transmitter fed by a small write FIFO.
// Divisor and stall are sampled only at frame boundaries.
module uart_verici #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] baud_div_i,
  input  logic        we_i,
  input  logic        stall_i,
  input  logic [7:0]  data_i,
  output logic        full_o,
  output logic        empty_o,
  output logic        tx_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  state_t        state;
  logic [7:0]    shift;
  logic [15:0]   div;
  logic [15:0]   cnt;
  logic [2:0]    idx;

  logic          push;
  logic          pop;
  logic          can_launch;
  logic          bit_end;

  assign full_o  = (count == CW'(FIFO_DEPTH));
  assign empty_o = (count == '0) && (state == IDLE);

  assign can_launch = (count != '0) && !stall_i
                   && (baud_div_i != 16'd0);
  assign bit_end    = (cnt == div - 16'd1);

  // a pop happens only when the serializer takes a new frame
  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = can_launch;
      STOP:    pop = can_launch && bit_end;
      default: pop = 1'b0;
    endcase
  end

  // full is judged on the pre-edge count, so a same-cycle pop
  // does not make room for a write
  assign push = we_i && !full_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      tx_o  <= 1'b1;
      shift <= '0;
      div   <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            div   <= baud_div_i;
            cnt   <= '0;
            state <= START;
            tx_o  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            tx_o  <= shift[0];
            shift <= {1'b0, shift[7:1]};
            state <= DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              idx   <= idx + 3'd1;
              tx_o  <= shift[0];
              shift <= {1'b0, shift[7:1]};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              div   <= baud_div_i;
              state <= START;
              tx_o  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

  a_count_bound: assert property (
    @(posedge clk_i) disable iff (rst_i)
    count <= CW'(FIFO_DEPTH)
  );

  a_div_nonzero: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state != IDLE) |-> (div != 16'd0)
  );

endmodule

// File: tb/tb_uart_verici.sv
// Randomized and directed bench for uart_verici against
// a queue-based model of the FIFO and serial waveform.
module tb_uart_verici;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic        we;
  logic        stall;
  logic [7:0]  data;
  logic        full;
  logic        empty;
  logic        tx;

  int checks = 0;
  int passes = 0;

  byte unsigned fifo_q[$];
  bit           line_q[$];

  uart_verici #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .baud_div_i (div),
    .we_i       (we),
    .stall_i    (stall),
    .data_i     (data),
    .full_o     (full),
    .empty_o    (empty),
    .tx_o       (tx)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
  endtask

  // whole frame as 10*div line levels, start..stop
  task automatic launch(byte unsigned b);
    for (int k = 0; k < 10; k++) begin
      bit lv;
      if (k == 0) lv = 1'b0;
      else if (k == 9) lv = 1'b1;
      else lv = b[k-1];
      repeat (int'(div)) line_q.push_back(lv);
    end
  endtask

  task automatic model_edge();
    bit full_pre;
    bit boundary;
    full_pre = (fifo_q.size() == DEPTH);
    if (rst) begin
      fifo_q.delete();
      line_q.delete();
      return;
    end
    boundary = (line_q.size() <= 1);
    if (line_q.size() != 0) void'(line_q.pop_front());
    if (boundary && fifo_q.size() != 0 && !stall
        && div != 16'd0)
      launch(fifo_q.pop_front());
    if (we && !full_pre) fifo_q.push_back(data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tx", tx, line_q.size() != 0 ? line_q[0] : 1'b1);
    check("full", full, fifo_q.size() == DEPTH);
    check("empty", empty,
          fifo_q.size() == 0 && line_q.size() == 0);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic write(byte unsigned b);
    we = 1'b1;
    data = b;
    step();
    we = 1'b0;
  endtask

  task automatic run_until_size(int sz, int budget);
    while (line_q.size() != sz && budget > 0) begin
      step();
      budget--;
    end
    check("wait_budget", budget > 0, 1);
  endtask

  initial begin
    bit pat [10];
    int n;
    pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    rst = 1'b1;
    div = 16'd4;
    we = 1'b0;
    stall = 1'b0;
    data = 8'h00;
    @(posedge clk);
    model_edge();
    #1;
    step();
    check("rst_tx", tx, 1);
    check("rst_empty", empty, 1);
    rst = 1'b0;

    // 0xA5 at div 4
    write(8'hA5);
    for (int i = 0; i < 40; i++) begin
      step();
      check("a5_bit", tx, pat[i/4]);
    end
    step();
    check("a5_empty", empty, 1);

    // stalled burst of 9 at div 2
    div = 16'd2;
    stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      write(8'(8'h10 + i));
      if (i == 7) check("full_after_8", full, 1);
    end
    run(5);
    stall = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!empty && n < 400);
    check("burst_len", n, 161);

    // divisor 0 disables, then 3 starts at once
    div = 16'd0;
    write(8'h55);
    run(10);
    check("div0_idle", tx, 1);
    div = 16'd3;
    step();
    check("start_latency", tx, 0);
    run(32);

    // mid-frame divisor change and stall
    div = 16'd4;
    write(8'h3C);
    write(8'hC3);
    run(10);
    div = 16'd8;
    stall = 1'b1;
    run_until_size(0, 100);
    run(20);
    check("stall_hold", tx, 1);
    check("stall_pending", empty, 0);
    stall = 1'b0;
    run(90);

    // write dropped on the popping edge while full
    div = 16'd2;
    for (int i = 0; i < 9; i++) write(8'(8'hB0 + i));
    check("full_setup", full, 1);
    run_until_size(1, 100);
    we = 1'b1;
    data = 8'hEE;
    step();
    we = 1'b0;
    check("drop_on_pop", full, 0);
    write(8'h77);
    check("refill", full, 1);
    stall = 1'b1;
    run_until_size(0, 100);
    stall = 1'b0;
    run(200);

    // reset during data bit 3, write ignored in reset
    div = 16'd4;
    write(8'h96);
    run_until_size(22, 100);
    rst = 1'b1;
    we = 1'b1;
    data = 8'hFF;
    step();
    check("rst_mid_tx", tx, 1);
    check("rst_mid_empty", empty, 1);
    rst = 1'b0;
    we = 1'b0;
    step();
    check("rst_we_ignored", empty, 1);
    write(8'h5A);
    run(45);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      we = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
      if ($urandom_range(0, 49) == 0) stall = ~stall;
      if ($urandom_range(0, 149) == 0)
        div = 16'($urandom_range(0, 5));
      step();
    end
    rst = 1'b0;
    we = 1'b0;
    stall = 1'b0;
    div = 16'd1;
    run(200);
    check("final_empty", empty, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
